// File: rtl/float_adder_rne_if.sv
// Handshake bundle for float_adder_rne.
//   in_valid/in_ready  : operand channel carrying a, b and sub
//   out_valid/out_ready: result channel carrying y and flags {invalid, overflow, underflow, zero}
// The master modport drives operands and consumes results; the slave modport is the adder.
interface float_adder_rne_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/float_adder_rne.sv
// Iterative floating-point add/subtract with round-to-nearest-even.
// Format is {sign, EXP_W exponent, MAN_W stored mantissa}; subnormal inputs are flushed to zero.
// One operation is in flight at a time; normalisation shifts left one bit per cycle.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of float_adder_rne_if (operand and result handshakes)
// flags = {invalid, overflow, underflow, zero}
module float_adder_rne #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic                clock,
  input  logic                reset_n,
  float_adder_rne_if.slave    bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned VW = MAN_W + 4;  // hidden + mantissa + G/R/S
  localparam int unsigned SW = MAN_W + 5;  // carry + VW
  localparam int unsigned XW = EXP_W + 1;  // exponent with headroom for overflow detection

  localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [XW-1:0] EXP_ONE = XW'(1);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   a_q, b_q;       // b_q already carries the effective (sub-adjusted) sign
  logic           sign_q;
  logic           eff_sub_q;
  logic [XW-1:0]  exp_q;
  logic [VW-1:0]  vl_q, vs_q;     // larger / aligned smaller significand
  logic [SW-1:0]  work_q;
  logic [W-1:0]   y_q;
  logic [3:0]     flags_q;
  logic           out_valid_q;

  // Operand decode
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa = a_q[W-1];
  assign sb = b_q[W-1];
  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign ma = a_q[MAN_W-1:0];
  assign mb = b_q[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  // Special-case resolution
  logic           spec_hit;
  logic [W-1:0]   spec_y;
  logic [3:0]     spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_y     = '0;
    spec_flags = 4'b0000;
    if (a_nan || b_nan) begin
      spec_y = QNAN;
    end else if (a_inf && b_inf) begin
      if (sa != sb) begin
        spec_y     = QNAN;
        spec_flags = 4'b1000;
      end else begin
        spec_y = a_q;
      end
    end else if (a_inf) begin
      spec_y = a_q;
    end else if (b_inf) begin
      spec_y = b_q;
    end else if (a_zero && b_zero) begin
      spec_y     = {sa & sb, {(W-1){1'b0}}};
      spec_flags = 4'b0001;
    end else if (a_zero) begin
      spec_y = b_q;
    end else if (b_zero) begin
      spec_y = a_q;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Alignment: larger-magnitude operand becomes A, smaller significand shifted with sticky
  logic               a_big;
  logic               s_big;
  logic [EXP_W-1:0]   e_big, e_small, exp_diff;
  logic [MAN_W-1:0]   m_big, m_small;
  logic [VW-1:0]      vec_small, vs_shift;
  logic               lost;
  int unsigned        shamt;

  assign a_big    = (ea > eb) || ((ea == eb) && (ma >= mb));
  assign s_big    = a_big ? sa : sb;
  assign e_big    = a_big ? ea : eb;
  assign e_small  = a_big ? eb : ea;
  assign m_big    = a_big ? ma : mb;
  assign m_small  = a_big ? mb : ma;
  assign exp_diff = e_big - e_small;

  always_comb begin
    shamt = 32'(exp_diff);
    if (shamt > MAN_W + 3) shamt = MAN_W + 3;
    vec_small = {1'b1, m_small, 3'b000};
    lost      = 1'b0;
    for (int unsigned i = 0; i < VW; i++) begin
      if (i < shamt) lost = lost | vec_small[i];
    end
    vs_shift    = vec_small >> shamt;
    vs_shift[0] = vs_shift[0] | lost;
  end

  // Add / subtract; vl_q >= vs_q, so the difference never borrows
  logic [SW-1:0] sum;
  assign sum = eff_sub_q ? ({1'b0, vl_q} - {1'b0, vs_q}) : ({1'b0, vl_q} + {1'b0, vs_q});

  // Round to nearest even on {hidden, mantissa}; a carry out of rounding bumps the exponent
  logic                inc;
  logic [MAN_W+1:0]    rounded;
  logic [XW-1:0]       exp_r;

  assign inc     = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
  assign rounded = {1'b0, work_q[SW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
  assign exp_r   = exp_q + {{EXP_W{1'b0}}, rounded[MAN_W+1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      vl_q        <= '0;
      vs_q        <= '0;
      work_q      <= '0;
      y_q         <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
            flags_q <= 4'b0000;
            state_q <= StAlign;
          end
        end
        StAlign: begin
          if (spec_hit) begin
            y_q         <= spec_y;
            flags_q     <= spec_flags;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            sign_q    <= s_big;
            eff_sub_q <= sa ^ sb;
            exp_q     <= {1'b0, e_big};
            vl_q      <= {1'b1, m_big, 3'b000};
            vs_q      <= vs_shift;
            state_q   <= StAdd;
          end
        end
        StAdd: begin
          if (sum == '0) begin
            y_q         <= '0;
            flags_q     <= 4'b0001;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            work_q  <= sum;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (work_q[SW-1]) begin
            work_q  <= {1'b0, work_q[SW-1:2], work_q[1] | work_q[0]};
            exp_q   <= exp_q + EXP_ONE;
            state_q <= StRound;
          end else if (!work_q[SW-2]) begin
            if (exp_q == EXP_ONE) begin
              // Result would be subnormal: flush to signed zero
              y_q         <= {sign_q, {(W-1){1'b0}}};
              flags_q     <= 4'b0011;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              work_q <= work_q << 1;
              exp_q  <= exp_q - EXP_ONE;
            end
          end else begin
            state_q <= StRound;
          end
        end
        StRound: begin
          if (exp_r >= EXP_MAX) begin
            y_q     <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_q <= 4'b0100;
          end else begin
            y_q <= {sign_q, exp_r[EXP_W-1:0], rounded[MAN_W-1:0]};
          end
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_float_adder_rne.sv
// Directed bench for float_adder_rne in bf16 (EXP_W=8, MAN_W=7).
// Each vector carries a hand-computed result, flags and accept-to-out_valid latency in edges.
module tb_float_adder_rne;
  logic clock = 1'b0;
  logic reset_n;

  int n_cmp = 0;
  int n_err = 0;

  float_adder_rne_if #(.W(16)) bus ();

  float_adder_rne #(
    .EXP_W(8),
    .MAN_W(7)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Issue one operation, measure latency, optionally stall the consumer, then drain.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic [15:0] ey, input logic [3:0] ef,
                        input int elat, input int hold);
    int lat;
    @(negedge clock);
    check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a         = av;
    bus.b         = bv;
    bus.sub       = sv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    if (elat >= 0) check_eq({tag, " latency"}, 32'(lat), 32'(elat));
    check_eq({tag, " y"}, 32'(bus.y), 32'(ey));
    check_eq({tag, " flags"}, 32'(bus.flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check_eq({tag, " hold y"}, 32'(bus.y), 32'(ey));
      check_eq({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, " drained"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, " idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset y", 32'(bus.y), 32'd0);
    check_eq("reset flags", 32'(bus.flags), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //         tag              a         b         sub   y         flags    lat hold
    run_op("add 1+2",        16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000, 4, 0);
    run_op("sub k7",         16'h3F80, 16'h3F7E, 1'b1, 16'h3C00, 4'b0000, 11, 0);
    run_op("rne tie even",   16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0000, 4, 0);
    run_op("rne tie odd",    16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 4'b0000, 4, 0);
    run_op("round carry",    16'h3FFF, 16'h3B80, 1'b0, 16'h4000, 4'b0000, 4, 0);
    run_op("add carry",      16'h3F80, 16'h3F80, 1'b0, 16'h4000, 4'b0000, 4, 0);
    run_op("sub 2-1",        16'h4000, 16'h3F80, 1'b1, 16'h3F80, 4'b0000, 5, 0);
    run_op("neg -1+0.5",     16'hBF80, 16'h3F00, 1'b0, 16'hBF00, 4'b0000, 5, 0);
    run_op("overflow",       16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'b0100, 4, 0);
    run_op("inf-inf",        16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 4'b1000, 1, 0);
    run_op("nan in",         16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'b0000, 1, 0);
    run_op("inf pass",       16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 4'b0000, 1, 0);
    run_op("cancel",         16'h3F80, 16'h3F80, 1'b1, 16'h0000, 4'b0001, 2, 0);
    run_op("ftz a",          16'h0001, 16'h3F80, 1'b0, 16'h3F80, 4'b0000, 1, 0);
    run_op("zero sub b",     16'h0000, 16'h3F80, 1'b1, 16'hBF80, 4'b0000, 1, 0);
    run_op("-0 + -0",        16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0001, 1, 0);
    run_op("-0 - -0",        16'h8000, 16'h8000, 1'b1, 16'h0000, 4'b0001, 1, 0);
    run_op("underflow",      16'h0100, 16'h00FF, 1'b1, 16'h0000, 4'b0011, 4, 0);
    run_op("stall",          16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000, 4, 10);
    run_op("flags cleared",  16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000, 4, 0);

    // Asynchronous reset while normalising
    @(negedge clock);
    bus.a        = 16'h3F80;
    bus.b        = 16'h3F7E;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("pre-reset busy", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mid reset y", 32'(bus.y), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("after reset",    16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
